// File: rtl/cond_unit.sv
// ============================================================================
//  Module   : cond_unit
//  Purpose  : Conditional-execution stage: holds NZCV, evaluates the condition
//             field and gates the PC/register/memory write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_unit #(
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    input  logic       no_write_i,
    output logic       pcsrc_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       cond_ex_o,
    output logic [3:0] flags_o
);

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;

    assign w_n = nz_q[1];
    assign w_z = nz_q[0];
    assign w_c = cv_q[1];
    assign w_v = cv_q[0];

    // Decoded on the registered flags only, so a flag write is seen next cycle.
    always_comb begin
        w_cond_ex = 1'b0;
        case (cond_i)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (en_i && w_cond_ex) begin
            if (flag_w_i[1]) nz_d = alu_flags_i[3:2];
            if (flag_w_i[0]) cv_d = alu_flags_i[1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nz_q <= RST_FLAGS[3:2];
            cv_q <= RST_FLAGS[1:0];
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

    // Strobes are deliberately not qualified by en_i; stalls are handled upstream.
    assign cond_ex_o   = w_cond_ex;
    assign pcsrc_o     = pcs_i & w_cond_ex;
    assign reg_write_o = reg_w_i & w_cond_ex & ~no_write_i;
    assign mem_write_o = mem_w_i & w_cond_ex;
    assign flags_o     = {nz_q, cv_q};

endmodule

`default_nettype wire
